// File: rtl/fpcvt_seq.sv
// Sequential two's-complement to sign/exponent/mantissa converter (value = F*2^E).
// Optional round-half-up with saturation when FPCVT_ROUND_EN is defined; truncation otherwise.
module fpcvt_seq #(
    parameter int DW = 12,
    parameter int EW = 3,
    parameter int FW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] D,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          S,
    output logic [EW-1:0] E,
    output logic [FW-1:0] F
);

    localparam int            EMAX   = DW - 1 - FW;
    localparam logic [EW-1:0] E_MAX  = EW'(EMAX);
    localparam logic [FW-1:0] F_HALF = {1'b1, {(FW-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, NORM, RND, DONE} state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic [DW-2:0] r_mag;
    logic [EW-1:0] r_ec;
    logic          r_sign;
    logic          r_s;
    logic [EW-1:0] r_e;
    logic [FW-1:0] r_f;

    logic [DW-1:0] w_abs;
    logic [DW-2:0] w_mag;
    logic          w_norm_done;
    logic [FW-1:0] w_fm;
    logic [FW-1:0] w_f_rnd;
    logic [EW-1:0] w_e_rnd;

    // The most negative sample has no positive counterpart; clamp its magnitude.
    assign w_abs       = D[DW-1] ? (~D + DW'(1)) : D;
    assign w_mag       = w_abs[DW-1] ? {(DW-1){1'b1}} : w_abs[DW-2:0];
    assign w_norm_done = r_mag[DW-2] || (r_ec == '0);
    assign w_fm        = r_mag[DW-2 -: FW];

    always_comb begin
        w_f_rnd = w_fm;
        w_e_rnd = r_ec;
`ifdef FPCVT_ROUND_EN
        if (r_mag[DW-2-FW]) begin
            if (w_fm != '1) begin
                w_f_rnd = w_fm + FW'(1);
            end else if (r_ec != E_MAX) begin
                w_f_rnd = F_HALF;
                w_e_rnd = r_ec + EW'(1);
            end
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (in_valid) w_state_next = NORM;
            NORM:    if (w_norm_done) w_state_next = RND;
            RND:     w_state_next = DONE;
            DONE:    if (out_ready) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mag  <= '0;
            r_ec   <= '0;
            r_sign <= 1'b0;
            r_s    <= 1'b0;
            r_e    <= '0;
            r_f    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_sign <= D[DW-1];
                        r_mag  <= w_mag;
                        r_ec   <= E_MAX;
                    end
                end
                NORM: begin
                    if (!w_norm_done) begin
                        r_mag <= {r_mag[DW-3:0], 1'b0};
                        r_ec  <= r_ec - EW'(1);
                    end
                end
                RND: begin
                    r_s <= r_sign;
                    r_e <= w_e_rnd;
                    r_f <= w_f_rnd;
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE) && !rst;
    assign out_valid = (r_state == DONE);
    assign S         = r_s;
    assign E         = r_e;
    assign F         = r_f;

endmodule

// File: doc/fpcvt_seq.md
# fpcvt_seq

Sequential, parametrised successor to the 12-bit combinational linear-to-float converter. It accepts a DW-bit two's-complement sample through a valid/ready handshake and normalises it iteratively, one shift per cycle. It emits sign/exponent/mantissa (value = F·2^E) with round-half-up and saturation, holding the result until the consumer takes it. It sits between a sample source and downstream display/encoding logic in the lab datapath.

## Interface
- DW, 12, input width (two's complement), ≥ FW+2
- EW, 3, exponent width; must satisfy 2^EW−1 ≥ DW−1−FW
- FW, 4, mantissa width
- clk  input  1  system clock; all state changes on rising edge
- rst  input  1  reset, synchronous, active-high
- in_valid  input  1  D is valid
- in_ready  output  1  block can accept (high only in IDLE)
- D  input  DW  two's-complement sample
- out_valid  output  1  S/E/F valid
- out_ready  input  1  consumer takes result
- S  output  1  sign
- E  output  EW  exponent
- F  output  FW  mantissa

## Operation
- Derived constant: EMAX = DW−1−FW (7 at defaults).
- FSM states: IDLE, NORM, RND, DONE.
- IDLE: in_ready=1. On in_valid: register S=D[DW−1]; magnitude M=|D|; if D=−2^(DW−1), M=2^(DW−1)−1 (saturate); exponent counter ec=EMAX; go NORM.
- NORM: if M[DW−2]=1 or ec=0 → RND; else M<<=1 (zero fill), ec−=1, stay.
- RND: Fm=M[DW−2:DW−1−FW], r=M[DW−2−FW].
  - If r=0: F=Fm, E=ec.
  - If r=1 and Fm<2^FW−1: F=Fm+1, E=ec.
  - If r=1, Fm=2^FW−1, ec<EMAX: F=2^(FW−1), E=ec+1.
  - If r=1, Fm=2^FW−1, ec=EMAX: F=2^FW−1, E=EMAX (saturate).
  - Register S/E/F, set out_valid=1, go DONE.
- DONE: hold S/E/F/out_valid stable; on out_ready → out_valid=0, IDLE.
- Zero input: S=0, E=0, F=0.
- in_valid ignored outside IDLE; D need only be stable in the accept cycle.

## Timing
- Reset values: in_ready=0 during rst, 1 the cycle after; out_valid=0, S=0, E=0, F=0; state IDLE.
- Accept at edge 0; s = number of NORM shifts = min(lz−1, EMAX), where lz = leading zeros of M over DW bits.
- out_valid rises after edge s+2; latency s+2 cycles (2 min, EMAX+2 = 9 max at defaults).
- Result accepted on the edge where out_valid & out_ready; in_ready rises in the same cycle (IDLE); the next accept occurs no earlier than the following edge.
- out_ready low: DONE held indefinitely; no output change.
- rst mid-operation (any state): abort, pending sample discarded, all outputs to reset values at that edge.
- Throughput ≤ one conversion per s+3 cycles.

## Configuration
- FPCVT_ROUND_EN defined: rounding per the RND rules above.
- Not defined: truncation, F=Fm, E=ec always; RND state kept, latency identical.

## Test plan
- D=422 (0x1A6) → S=0, E=5, F=13 (416); out_valid 4 cycles after accept; −422 → S=1, E=5, F=13.
- D=125 → S=0, E=4, F=8 (mantissa overflow bumps exponent); D=−46 → S=1, E=2, F=12; without FPCVT_ROUND_EN, D=46 → E=2, F=11.
- D=2047 → E=7, F=15; D=−2048 → S=1, E=7, F=15 (saturation); D=−2047 → S=1, E=7, F=15.
- D=0 → S=0, E=0, F=0, out_valid 9 cycles after accept.
- Backpressure: out_ready low 5 cycles after out_valid → S/E/F stable, in_ready=0, new in_valid ignored; release → one-cycle handshake, in_ready=1 next.
- Assert rst during NORM for D=45 → outputs zero, IDLE; next D=45 → E=2, F=11 (44).
